// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds one accepted branch until every flag writer it
// depends on has committed, then resolves it against V/N/Z for the fetch stage.
module branch_cond_unit #(
    parameter int ADDR_W = 32,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              issue_z,
    input  logic              issue_vn,
    input  logic              wr_z,
    input  logic              wr_vn,
    input  logic              V,
    input  logic              N,
    input  logic              Z,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flush,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_target,
    output logic              cond_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [1:0]        state_q, state_d;
    logic [PEND_W-1:0] pend_z_q, pend_z_d;
    logic [PEND_W-1:0] pend_vn_q, pend_vn_d;
    logic              ovf_z, ovf_vn;
    logic [3:0]        cond_q, cond_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              res_taken_q, res_taken_d;
    logic [ADDR_W-1:0] res_target_q, res_target_d;
    logic              cond_err_q, cond_err_d;
    logic              wait_z, wait_vn, deps_clear;

    // Returns {error, next count}; simultaneous issue and commit cancel out.
    function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [PEND_W-1:0] nxt;
        logic              err;
        nxt = cnt;
        err = 1'b0;
        if (inc && !dec) begin
            if (cnt == PEND_MAX) err = 1'b1;
            else                 nxt = cnt + PEND_ONE;
        end else if (dec && !inc) begin
            if (cnt == '0) err = 1'b1;
            else           nxt = cnt - PEND_ONE;
        end
        return {err, nxt};
    endfunction

    function automatic logic cond_legal(input logic [3:0] cond);
        return cond <= 4'd10;
    endfunction

    // Returns {depends on Z, depends on V/N}.
    function automatic logic [1:0] cond_dep(input logic [3:0] cond);
        case (cond)
            4'd1, 4'd2:                      return 2'b10;
            4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10: return 2'b01;
            4'd5, 4'd6:                      return 2'b11;
            default:                         return 2'b00;
        endcase
    endfunction

    function automatic logic cond_eval(input logic [3:0] cond, input logic v,
                                       input logic n, input logic z);
        logic lt;
        lt = n ^ v;
        case (cond)
            4'd0:    return 1'b1;
            4'd1:    return z;
            4'd2:    return ~z;
            4'd3:    return lt;
            4'd4:    return ~lt;
            4'd5:    return ~z & ~lt;
            4'd6:    return z | lt;
            4'd7:    return v;
            4'd8:    return ~v;
            4'd9:    return n;
            4'd10:   return ~n;
            default: return 1'b0;
        endcase
    endfunction

    assign {wait_z, wait_vn} = cond_dep(cond_q);
    assign deps_clear = (!wait_z || pend_z_q == '0) && (!wait_vn || pend_vn_q == '0);

    assign br_ready   = clrn && (state_q == S_IDLE);
    assign res_valid  = (state_q == S_RESP);
    assign res_taken  = res_taken_q;
    assign res_target = res_target_q;
    assign cond_err   = cond_err_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path infers a latch.
        state_d      = state_q;
        cond_d       = cond_q;
        tgt_d        = tgt_q;
        res_taken_d  = res_taken_q;
        res_target_d = res_target_q;

        {ovf_z, pend_z_d}   = pend_next(pend_z_q, issue_z, wr_z);
        {ovf_vn, pend_vn_d} = pend_next(pend_vn_q, issue_vn, wr_vn);
        cond_err_d = cond_err_q | ovf_z | ovf_vn;

        // Flush drops the branch from any state; counters keep tracking writers.
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (br_valid && br_ready) begin
                        cond_d  = br_cond;
                        tgt_d   = br_target;
                        state_d = S_WAIT;
                        if (!cond_legal(br_cond)) cond_err_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (deps_clear) begin
                        res_taken_d  = cond_eval(cond_q, V, N, Z);
                        res_target_d = tgt_q;
                        state_d      = S_RESP;
                    end
                end
                S_RESP: begin
                    if (res_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_IDLE;
            pend_z_q     <= '0;
            pend_vn_q    <= '0;
            cond_q       <= '0;
            tgt_q        <= '0;
            res_taken_q  <= 1'b0;
            res_target_q <= '0;
            cond_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values.
            state_q      <= state_d;
            pend_z_q     <= pend_z_d;
            pend_vn_q    <= pend_vn_d;
            cond_q       <= cond_d;
            tgt_q        <= tgt_d;
            res_taken_q  <= res_taken_d;
            res_target_q <= res_target_d;
            cond_err_q   <= cond_err_d;
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: the driver pushes expected resolutions,
// a monitor pops and compares them on every res_valid/res_ready handshake.
module tb_branch_cond_unit;

    localparam int ADDR_W = 32;
    localparam int PEND_W = 2;

    logic              clk = 1'b0;
    logic              clrn = 1'b0;
    logic              issue_z = 1'b0, issue_vn = 1'b0;
    logic              wr_z = 1'b0, wr_vn = 1'b0;
    logic              V = 1'b0, N = 1'b0, Z = 1'b0;
    logic              br_valid = 1'b0;
    logic              br_ready;
    logic [3:0]        br_cond = 4'd0;
    logic [ADDR_W-1:0] br_target = '0;
    logic              flush = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              cond_err;

    always #5 clk = ~clk;

    branch_cond_unit #(.ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
        .clk(clk), .clrn(clrn),
        .issue_z(issue_z), .issue_vn(issue_vn), .wr_z(wr_z), .wr_vn(wr_vn),
        .V(V), .N(N), .Z(Z),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
        .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_target(res_target), .cond_err(cond_err)
    );

    typedef struct packed {
        logic              taken;
        logic [ADDR_W-1:0] target;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_exp;
    int    n_checks = 0;
    int    n_fail = 0;
    int    mode = 0;          // consumer: 0 always ready, 1 random, 2 stalled
    logic  err_exp = 1'b0;
    logic  hold_pend = 1'b0;
    logic  hold_taken;
    logic [ADDR_W-1:0] hold_tgt;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [ADDR_W-1:0] act,
                              input logic [ADDR_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: condition table evaluated on the flags the branch must observe.
    function automatic logic ref_taken(input logic [3:0] c, input logic v,
                                       input logic n, input logic z);
        logic lt;
        lt = (n != v);
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return lt;
            4'd4:  return !lt;
            4'd5:  return !z && !lt;
            4'd6:  return z || lt;
            4'd7:  return v;
            4'd8:  return !v;
            4'd9:  return n;
            4'd10: return !n;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: chooses res_ready for the coming edge, then scores any handshake.
    always @(negedge clk) begin
        if (!clrn) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check_bit("hold_valid", res_valid, 1'b1);
                check_bit("hold_taken", res_taken, hold_taken);
                check_word("hold_target", res_target, hold_tgt);
            end
            case (mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ($urandom_range(0, 3) != 0);
                default: res_ready = 1'b0;
            endcase
            hold_pend  = res_valid && !res_ready;
            hold_taken = res_taken;
            hold_tgt   = res_target;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got taken=%0b target=%0h, required no response",
                             res_taken, res_target);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_bit("res_taken", res_taken, mon_exp.taken);
                    check_word("res_target", res_target, mon_exp.target);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic tk, input logic [ADDR_W-1:0] t);
        resp_t r;
        r.taken  = tk;
        r.target = t;
        exp_q.push_back(r);
    endtask

    task automatic send(input logic [3:0] c, input logic [ADDR_W-1:0] t,
                        input logic iz, input logic ivn);
        int n = 0;
        while (!br_ready && n < 100) begin
            step();
            n++;
        end
        check_bit("br_ready_wait", br_ready, 1'b1);
        br_valid = 1'b1; br_cond = c; br_target = t; issue_z = iz; issue_vn = ivn;
        step();
        br_valid = 1'b0; issue_z = 1'b0; issue_vn = 1'b0;
    endtask

    // One flag-register commit; the new flag values appear after the edge.
    task automatic commit(input logic dz, input logic dvn, input logic nv,
                          input logic nn, input logic nz);
        wr_z = dz; wr_vn = dvn;
        step();
        wr_z = 1'b0; wr_vn = 1'b0;
        if (dz) Z = nz;
        if (dvn) begin V = nv; N = nn; end
    endtask

    task automatic no_resp(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_bit(name, res_valid, 1'b0);
            step();
        end
    endtask

    // res_valid must stay low until the lat-th negedge from now, then rise.
    task automatic wait_resolve(input int lat, input string name);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            check_bit(name, res_valid, i == lat);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check_bit(name, exp_q.size() == 0, 1'b1);
        step();
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        #1;
        check_bit("rst_res_valid", res_valid, 1'b0);
        check_bit("rst_br_ready", br_ready, 1'b0);
        check_bit("rst_res_taken", res_taken, 1'b0);
        check_word("rst_res_target", res_target, '0);
        check_bit("rst_cond_err", cond_err, 1'b0);
        exp_q.delete();
        err_exp = 1'b0;
        step();
        clrn = 1'b1;
        @(negedge clk);
        check_bit("rst_br_ready_after", br_ready, 1'b1);
        step();
    endtask

    task automatic eq_after_sub(input logic zval, input logic [ADDR_W-1:0] t);
        Z = !zval;
        push_exp(zval, t);
        send(4'd1, t, 1'b1, 1'b1);
        no_resp(2, "eq_sub_wait");
        wr_z = 1'b1; wr_vn = 1'b1;
        @(negedge clk);
        check_bit("eq_sub_wait", res_valid, 1'b0);
        step();
        wr_z = 1'b0; wr_vn = 1'b0; Z = zval; V = 1'b0; N = 1'b0;
        wait_resolve(2, "eq_sub_resolve");
        drain("eq_sub_drain");
    endtask

    task automatic rand_txn();
        logic [3:0]        c;
        logic [ADDR_W-1:0] t;
        int                nzw, nvw, k;
        logic              fv, fn, fz;
        c   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
        t   = $urandom;
        nzw = $urandom_range(0, 2);
        nvw = $urandom_range(0, 2);
        fv  = 1'($urandom_range(0, 1));
        fn  = 1'($urandom_range(0, 1));
        fz  = 1'($urandom_range(0, 1));
        // Pending writers decide the flags; otherwise the current flags hold.
        push_exp(ref_taken(c, (nvw > 0) ? fv : V, (nvw > 0) ? fn : N, (nzw > 0) ? fz : Z), t);
        if (c > 4'd10) err_exp = 1'b1;
        k = (nzw > nvw) ? nzw : nvw;
        for (int i = 0; i < k - 1; i++) begin
            issue_z  = (i >= k - nzw);
            issue_vn = (i >= k - nvw);
            step();
        end
        issue_z = 1'b0; issue_vn = 1'b0;
        send(c, t, nzw > 0, nvw > 0);
        repeat ($urandom_range(0, 3)) step();
        for (int j = 0; j < k; j++) begin
            commit(j < nzw, j < nvw,
                   (j == nvw - 1) ? fv : 1'($urandom_range(0, 1)),
                   (j == nvw - 1) ? fn : 1'($urandom_range(0, 1)),
                   (j == nzw - 1) ? fz : 1'($urandom_range(0, 1)));
        end
        drain("rand_drain");
        check_bit("rand_cond_err", cond_err, err_exp);
    endtask

    initial begin
        #12;
        check_bit("init_res_valid", res_valid, 1'b0);
        check_bit("init_br_ready", br_ready, 1'b0);
        check_bit("init_cond_err", cond_err, 1'b0);
        step();
        clrn = 1'b1;
        @(negedge clk);
        check_bit("init_br_ready_after", br_ready, 1'b1);
        step();

        // ALWAYS at minimum latency, held three cycles under backpressure.
        mode = 2;
        push_exp(1'b1, 32'h0000_1000);
        send(4'd0, 32'h0000_1000, 1'b0, 1'b0);
        wait_resolve(2, "always_latency");
        check_bit("always_taken", res_taken, 1'b1);
        check_word("always_target", res_target, 32'h0000_1000);
        check_bit("resp_br_ready", br_ready, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_bit("always_held", res_valid, 1'b1);
        end
        step();
        mode = 0;
        step();
        @(negedge clk);
        check_bit("always_release", res_valid, 1'b0);
        check_bit("always_idle", br_ready, 1'b1);
        step();

        // Reset while a branch waits on a Z writer.
        Z = 1'b0;
        send(4'd1, 32'h0000_2000, 1'b1, 1'b0);
        no_resp(1, "rst_wait");
        do_reset();
        Z = 1'b1;
        push_exp(1'b1, 32'h0000_2004);
        send(4'd1, 32'h0000_2004, 1'b0, 1'b0);
        wait_resolve(2, "rst_cleared_pend");
        drain("rst_drain");

        eq_after_sub(1'b1, 32'h0000_3000);
        eq_after_sub(1'b0, 32'h0000_3100);

        // Only V/N pending: EQ ignores it, LT waits for it.
        Z = 1'b1;
        push_exp(1'b1, 32'h0000_4000);
        send(4'd1, 32'h0000_4000, 1'b0, 1'b1);
        wait_resolve(2, "dep_eq_nowait");
        drain("dep_drain");
        commit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(1'b1, 32'h0000_4100);
        send(4'd3, 32'h0000_4100, 1'b0, 1'b1);
        no_resp(2, "dep_lt_wait");
        commit(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_resolve(2, "dep_lt_resolve");
        drain("dep_drain");

        // Simultaneous issue and commit leave the count unchanged.
        do_reset();
        issue_z = 1'b1; wr_z = 1'b1; step();
        wr_z = 1'b0; step();
        wr_z = 1'b1; step();
        issue_z = 1'b0; wr_z = 1'b0;
        push_exp(1'b1, 32'h0000_5000);
        Z = 1'b0;
        send(4'd1, 32'h0000_5000, 1'b0, 1'b0);
        no_resp(2, "both_wait");
        commit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_resolve(2, "both_resolve");
        drain("both_drain");
        check_bit("both_no_err", cond_err, 1'b0);

        // Saturation at 2^PEND_W-1 in flight.
        do_reset();
        issue_z = 1'b1;
        repeat (3) step();
        issue_z = 1'b0;
        @(negedge clk);
        check_bit("sat_before", cond_err, 1'b0);
        step();
        issue_z = 1'b1; step();
        issue_z = 1'b0;
        @(negedge clk);
        check_bit("sat_err", cond_err, 1'b1);
        step();
        commit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        commit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(1'b0, 32'h0000_6000);
        send(4'd1, 32'h0000_6000, 1'b0, 1'b0);
        no_resp(2, "sat_wait");
        commit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_resolve(2, "sat_resolve");
        drain("sat_drain");
        check_bit("sat_err_sticky", cond_err, 1'b1);

        // Underflow clamps at zero.
        do_reset();
        commit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_bit("under_err", cond_err, 1'b1);
        step();
        push_exp(1'b1, 32'h0000_7000);
        send(4'd3, 32'h0000_7000, 1'b0, 1'b1);
        no_resp(2, "under_wait");
        commit(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_resolve(2, "under_resolve");
        drain("under_drain");

        // Illegal condition: no dependency, not taken, sticky error.
        do_reset();
        Z = 1'b1;
        push_exp(1'b0, 32'h0000_8000);
        send(4'd12, 32'h0000_8000, 1'b1, 1'b1);
        wait_resolve(2, "illegal_latency");
        drain("illegal_drain");
        check_bit("illegal_err", cond_err, 1'b1);
        commit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flush in WAIT drops the branch but not the pending writer.
        do_reset();
        Z = 1'b0;
        send(4'd1, 32'h0000_9000, 1'b1, 1'b0);
        no_resp(1, "flush_wait");
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check_bit("flush_idle", br_ready, 1'b1);
        step();
        no_resp(3, "flush_no_pulse");
        commit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(1'b1, 32'h0000_9100);
        send(4'd1, 32'h0000_9100, 1'b0, 1'b0);
        wait_resolve(2, "flush_next");
        drain("flush_drain");
        check_bit("flush_no_err", cond_err, 1'b0);

        // Randomized traffic with random consumer backpressure.
        do_reset();
        mode = 1;
        for (int i = 0; i < 60; i++) rand_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
